// File: rtl/uart_led_pkg.sv
// uart_led_pkg: shared FSM states, frame constants and helpers for uart_led_ctrl
package uart_led_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_CMD  = 2'd1,
        S_ARG  = 2'd2,
        S_CHK  = 2'd3
    } led_fsm_t;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_SET    = 8'h02;
    localparam logic [7:0] OP_CLEAR  = 8'h03;
    localparam logic [7:0] OP_BLINK  = 8'h04;

    // Saturating byte increment: holds at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/led_blink_div.sv
// led_blink_div: free-running divider producing a square-wave blink phase
module led_blink_div #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic phase
);

    localparam int HALF = (CLK_HZ / (2 * BLINK_HZ)) > 0 ? CLK_HZ / (2 * BLINK_HZ) : 1;
    localparam int W    = HALF > 1 ? $clog2(HALF) : 1;
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] cnt;

    // Count 0..HALF-1 and flip the phase each time the counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_led_ctrl.sv
// uart_led_ctrl: checksummed UART frame decoder driving an LED bank.
// Blink support (divider, mask, opcode 0x04) is built only when
// UART_LED_CTRL_BLINK_EN is defined; otherwise 0x04 is an unknown opcode.
module uart_led_ctrl import uart_led_pkg::*; #(
    parameter int N_LEDS      = 8,
    parameter int CLK_HZ      = 50_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [N_LEDS-1:0] leds,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [7:0]        err_cnt
);

    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

    led_fsm_t          fsm, fsm_d;
    logic              rx_valid_q;
    logic [7:0]        cmd, arg;
    logic [TW-1:0]     to_cnt;
    logic [N_LEDS-1:0] state, state_d, st_arg;
    logic              take, chk_ok, known, exec, bad, tmo;

    assign st_arg = arg[N_LEDS-1:0];

`ifdef UART_LED_CTRL_BLINK_EN
    logic              phase;
    logic [N_LEDS-1:0] mask, mask_d;

    led_blink_div #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase)
    );

    assign known  = cmd inside {OP_WRITE, OP_SET, OP_CLEAR, OP_BLINK};
    assign mask_d = (exec && cmd == OP_BLINK) ? st_arg : mask;

    // Blink mask register, loaded only by an accepted blink frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask <= '0;
        else        mask <= mask_d;
    end

    // LEDs follow the next state so they change together with frame_ok.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) leds <= '0;
        else        leds <= state_d ^ (mask_d & {N_LEDS{phase}});
    end
`else
    assign known = cmd inside {OP_WRITE, OP_SET, OP_CLEAR};

    // LEDs follow the next state so they change together with frame_ok.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) leds <= '0;
        else        leds <= state_d;
    end
`endif

    // Byte strobe, frame verdict, timeout and next-state decode.
    always_comb begin
        take    = rx_valid & ~rx_valid_q;
        chk_ok  = (cmd ^ arg) == rx_data;
        exec    = take && fsm == S_CHK && chk_ok && known;
        bad     = take && fsm == S_CHK && !(chk_ok && known);
        tmo     = !take && fsm != S_SYNC && to_cnt == TO_MAX;
        state_d = !exec             ? state :
                  cmd == OP_WRITE   ? st_arg :
                  cmd == OP_SET     ? state | st_arg :
                  cmd == OP_CLEAR   ? state & ~st_arg : state;
        fsm_d   = fsm;
        if (tmo) fsm_d = S_SYNC;
        else if (take) begin
            case (fsm)
                S_SYNC:  fsm_d = (rx_data == SYNC_BYTE) ? S_CMD : S_SYNC;
                S_CMD:   fsm_d = S_ARG;
                S_ARG:   fsm_d = S_CHK;
                default: fsm_d = S_SYNC;
            endcase
        end
    end

    // Frame parser registers: edge detector, FSM, latched CMD/ARG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            fsm        <= S_SYNC;
            cmd        <= '0;
            arg        <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            fsm        <= fsm_d;
            if (take && fsm == S_CMD) cmd <= rx_data;
            if (take && fsm == S_ARG) arg <= rx_data;
        end
    end

    // Inter-byte idle counter; held clear while hunting for SYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            to_cnt <= '0;
        else if (take || tmo || fsm == S_SYNC) to_cnt <= '0;
        else                                   to_cnt <= to_cnt + TW'(1);
    end

    // LED state, status pulses and the saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_d;
            frame_ok  <= exec;
            frame_err <= bad | tmo;
            if (bad | tmo) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_uart_led_ctrl.sv
// tb_uart_led_ctrl: directed frame tests for uart_led_ctrl (UART_LED_CTRL_BLINK_EN aware)
module tb_uart_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] leds;
    logic       frame_ok, frame_err;
    logic [7:0] err_cnt;

    int vec = 0, bad = 0, n_ok = 0, n_err = 0;
    int o, e, at;
    logic [1:0] ph_a, ph_b;

    uart_led_ctrl #(
        .N_LEDS      (8),
        .CLK_HZ      (20),
        .BLINK_HZ    (1),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .leds      (leds),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Count every cycle each status pulse is high.
    always @(negedge clk) begin
        if (frame_ok)  n_ok++;
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send_byte(8'h55);
        send_byte(c);
        send_byte(a);
        send_byte(k);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_leds", leds, 8'h00);
        check("rst_ok", frame_ok, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_errcnt", err_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        o = n_ok;
        send_frame(8'h01, 8'hA5, 8'hA4);
        check("write_leds", leds, 8'hA5);
        check("write_okpulse", n_ok - o, 1);
        check("write_errcnt", err_cnt, 8'h00);
        send_frame(8'h02, 8'h0A, 8'h08);
        check("set_leds", leds, 8'hAF);
        send_frame(8'h03, 8'h21, 8'h22);
        check("clear_leds", leds, 8'h8E);
        check("ok_pulses", n_ok - o, 3);

        e = n_err;
        send_frame(8'h01, 8'hFF, 8'h00);
        send_frame(8'h07, 8'h00, 8'h07);
        check("bad_leds", leds, 8'h8E);
        check("bad_pulses", n_err - e, 2);
        check("bad_errcnt", err_cnt, 8'h02);
        check("bad_nook", n_ok - o, 3);

        send_byte(8'h55);
        send_byte(8'h01);
        at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (frame_err && at < 0) at = i;
        end
        check("tmo_latency", at, 16);
        check("tmo_errcnt", err_cnt, 8'h03);
        send_frame(8'h01, 8'h3C, 8'h3D);
        check("tmo_recover", leds, 8'h3C);

        e = n_err;
        send_byte(8'h55);
        repeat (14) @(negedge clk);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5B);
        @(negedge clk);
        #1;
        check("tie_leds", leds, 8'h5A);
        check("tie_noerr", n_err - e, 0);
        check("tie_errcnt", err_cnt, 8'h03);

`ifdef UART_LED_CTRL_BLINK_EN
        send_frame(8'h04, 8'h03, 8'h07);
        check("blink_upper", leds[7:2], 6'h16);
        ph_a = leds[1:0];
        repeat (10) @(negedge clk);
        ph_b = leds[1:0];
        check("blink_toggle", ph_a ^ ph_b, 2'b11);
        check("blink_upper2", leds[7:2], 6'h16);
        send_frame(8'h04, 8'h00, 8'h04);
        check("blink_off", leds, 8'h5A);
        check("blink_errcnt", err_cnt, 8'h03);
`else
        e = n_err;
        send_frame(8'h04, 8'h03, 8'h07);
        check("noblink_leds", leds, 8'h5A);
        check("noblink_pulse", n_err - e, 1);
        check("noblink_errcnt", err_cnt, 8'h04);
`endif

        e = n_err;
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (50) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        #1;
        check("hold_pulses", n_err - e, 1);
        check("hold_leds", leds, 8'h5A);

        o = n_ok;
        send_byte(8'h55);
        send_byte(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_leds", leds, 8'h00);
        check("arst_errcnt", err_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hA5);
        send_byte(8'hA4);
        @(negedge clk);
        #1;
        check("arst_discard", leds, 8'h00);
        check("arst_nook", n_ok - o, 0);
        send_frame(8'h02, 8'h81, 8'h83);
        check("arst_recover", leds, 8'h81);

        e = n_err;
        for (int i = 0; i < 256; i++) send_frame(8'h01, 8'hFF, 8'h00);
        check("sat_errcnt", err_cnt, 8'hFF);
        check("sat_pulses", n_err - e, 256);
        check("sat_leds", leds, 8'h81);
        send_frame(8'h03, 8'h01, 8'h02);
        check("sat_after_ok", leds, 8'h80);
        check("sat_hold", err_cnt, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/uart_led_ctrl.md
# uart_led_ctrl

Parametrised UART command decoder driving a bank of up to 8 LEDs. It sits between `uart_rx` (byte data plus a level `valid`) and the board LED pins. It parses checksummed 4-byte frames into write, set, clear and blink operations, drops malformed or stalled frames, and counts errors.

## Interface
Parameters:
- `N_LEDS`, 8, number of LEDs driven (1..8); uses `ARG[N_LEDS-1:0]`.
- `CLK_HZ`, 50_000_000, system clock frequency.
- `BLINK_HZ`, 2, blink toggle rate; half-period = `CLK_HZ/(2*BLINK_HZ)` cycles.
- `TIMEOUT_CYC`, 1_000_000, maximum idle cycles between bytes of one frame.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_valid` in 1: level valid from `uart_rx`; a byte is taken on its rising edge only.
- `leds` out N_LEDS: LED drive, registered.
- `frame_ok` out 1: 1-cycle pulse, frame executed.
- `frame_err` out 1: 1-cycle pulse, frame rejected or timed out.
- `err_cnt` out 8: saturating error count.

## Operation
- Edge detect: `rx_valid_q` register; `take = rx_valid & ~rx_valid_q`. Exactly one byte per rising edge; a held-high `rx_valid` is never re-taken.
- Frame format: `SYNC` (0x55), `CMD`, `ARG`, `CHK`, where `CHK = CMD ^ ARG`.
- FSM states and transitions, all on `take`:
  - `S_SYNC`: 0x55 → `S_CMD`; any other byte is ignored silently.
  - `S_CMD`: latch `CMD` → `S_ARG`. A 0x55 byte here is latched as a normal `CMD`.
  - `S_ARG`: latch `ARG` → `S_CHK`.
  - `S_CHK`: evaluate → `S_SYNC`.
- Commands, executed only if `CHK` matches and the opcode is known:
  - 0x01 WRITE: `state <= ARG`.
  - 0x02 SET: `state <= state | ARG`.
  - 0x03 CLEAR: `state <= state & ~ARG`.
  - 0x04 BLINK: `blink_mask <= ARG`.
- Bad checksum or unknown opcode: no state change, `frame_err` pulse, `err_cnt`+1.
- Output: `leds = state ^ (blink_mask & {N_LEDS{phase}})`, registered.
- Blink divider: counter runs 0..HALF-1; `phase` toggles on wrap; free-running from reset.
- Timeout: counter clears on every `take` and stays clear in `S_SYNC`. When outside `S_SYNC` it reaches `TIMEOUT_CYC-1`: → `S_SYNC`, `frame_err` pulse, `err_cnt`+1.
- `err_cnt` saturates at 255 and never wraps.

## Timing
- Reset values: `leds`=0, `frame_ok`=0, `frame_err`=0, `err_cnt`=0, `state`=0, `blink_mask`=0, `phase`=0, FSM=`S_SYNC`, all counters 0.
- `take` is high in the first cycle `rx_valid` is sampled high. The CHK byte is evaluated at that edge. `leds`, `frame_ok` and `frame_err` change 1 clock later and the pulses are exactly 1 cycle wide.
- Back-to-back frames are supported with no dead cycles; the next `SYNC` may arrive on the cycle after `CHK`.
- Timeout and `take` in the same cycle: the byte wins, the counter clears and no error is raised.
- `err_cnt` increment at 255: the value holds, but `frame_err` still pulses.
- `rst_n` low mid-frame: the partial frame is discarded immediately (async) and all outputs take reset values.

## Configuration
- `UART_LED_CTRL_BLINK_EN` defined: the blink divider, `blink_mask` and opcode 0x04 are compiled in.
- Not defined: no divider and no mask, `leds = state`, and 0x04 is treated as unknown (`frame_err`, `err_cnt`+1).

## Structure
- Package `uart_led_pkg`:
  - FSM state enum `led_fsm_t` (`S_SYNC`, `S_CMD`, `S_ARG`, `S_CHK`).
  - Constants `SYNC_BYTE`=8'h55, `OP_WRITE`, `OP_SET`, `OP_CLEAR`, `OP_BLINK`.
- Sub-module `led_blink_div`: parameters `CLK_HZ` and `BLINK_HZ`, output `phase`. Instantiated only under `UART_LED_CTRL_BLINK_EN`.

## Test plan
- Reset, then frame 55 01 A5 A4 → `leds`=8'hA5, one `frame_ok` pulse, `err_cnt`=0.
- From `leds`=A5, frames 55 02 0A 08, then 55 03 21 22 → `leds`=AF after the first frame, then 8E after the second.
- Frame 55 01 FF 00 (bad CHK), then 55 07 00 07 (unknown opcode) → `leds` unchanged, two `frame_err` pulses, `err_cnt`=2.
- Bytes 55 01 with `TIMEOUT_CYC`=16, then idle 20 cycles → `frame_err` pulse 16 cycles after the last byte; a following valid frame executes normally.
- With the macro and `CLK_HZ`=20, `BLINK_HZ`=1, frame 55 04 03 07 → `leds[1:0]` toggles every 10 cycles while the upper bits hold; without the macro → `frame_err`.
- `rx_valid` held high for 50 cycles with `rx_data`=55, plus `rst_n` pulsed low between CMD and ARG → only one byte taken, FSM back to `S_SYNC`, all outputs 0.
